// File: rtl/nor_gate_if.sv
// Bus bundle for nor_gate: operands in, combinational result plus clocked
// result/edge pulses and all-ones cycle counter out.
interface nor_gate_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_rise;
  logic [WIDTH-1:0] y_fall;
  logic [CNT_W-1:0] all_cnt;

  modport master (
    output a,
    output b,
    input  y,
    input  y_q,
    input  y_rise,
    input  y_fall,
    input  all_cnt
  );

  modport slave (
    input  a,
    input  b,
    output y,
    output y_q,
    output y_rise,
    output y_fall,
    output all_cnt
  );
endinterface

// File: rtl/nor_gate.sv
// Bitwise NOR leaf cell: combinational y, registered y_q with rise/fall pulses.
// Optional all-ones cycle counter built only when NOR_GATE_STATS_EN is defined.
module nor_gate #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic       clk,
  input  logic       rst,
  nor_gate_if.slave  bus
);

  logic [WIDTH-1:0] w_y;
  logic [WIDTH-1:0] r_y_q;
  logic [WIDTH-1:0] r_y_prev;
  logic [WIDTH-1:0] r_y_rise;
  logic [WIDTH-1:0] r_y_fall;

  // Plain NOR so X/Z on an operand propagates to y instead of being masked.
  assign w_y = ~(bus.a | bus.b);

  // Result register, one-cycle history, and registered edge pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_y_q    <= {WIDTH{1'b0}};
      r_y_prev <= {WIDTH{1'b0}};
      r_y_rise <= {WIDTH{1'b0}};
      r_y_fall <= {WIDTH{1'b0}};
    end else begin
      r_y_q    <= w_y;
      r_y_prev <= r_y_q;
      r_y_rise <= r_y_q & ~r_y_prev;
      r_y_fall <= ~r_y_q & r_y_prev;
    end
  end

  assign bus.y      = w_y;
  assign bus.y_q    = r_y_q;
  assign bus.y_rise = r_y_rise;
  assign bus.y_fall = r_y_fall;

`ifdef NOR_GATE_STATS_EN
  logic [CNT_W-1:0] r_all_cnt;
  logic             w_all_ones;
  logic             w_cnt_max;

  assign w_all_ones = &w_y;
  assign w_cnt_max  = &r_all_cnt;

  // Saturating tally of all-ones cycles; reset takes priority over counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_all_cnt <= {CNT_W{1'b0}};
    end else if (w_all_ones && !w_cnt_max) begin
      r_all_cnt <= r_all_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_all_cnt <= r_all_cnt;
    end
  end

  assign bus.all_cnt = r_all_cnt;
`else
  assign bus.all_cnt = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_nor_gate.sv
// Self-checking bench for nor_gate: directed scenarios plus randomized traffic
// against a history-based reference model.
module tb_nor_gate;
  localparam int W  = 4;
  localparam int CW = 2;

  logic clk  = 1'b0;
  logic rst  = 1'b1;
  logic rst1 = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  nor_gate_if #(.WIDTH(W), .CNT_W(CW)) bus4 ();
  nor_gate_if #(.WIDTH(1), .CNT_W(16)) bus1 ();

  nor_gate #(.WIDTH(W), .CNT_W(CW)) u_dut4 (.clk(clk), .rst(rst),  .bus(bus4));
  nor_gate #(.WIDTH(1), .CNT_W(16)) u_dut1 (.clk(clk), .rst(rst1), .bus(bus1));

  // Reference model: y samples taken at clock edges since the last reset.
  logic [W-1:0] hist[$];
  int           ones = 0;

  function automatic logic [W-1:0] hist_at(input int back);
    if (hist.size() > back) return hist[hist.size() - 1 - back];
    return {W{1'b0}};
  endfunction

  function automatic logic [W-1:0] exp_yq();
    return hist_at(0);
  endfunction

  function automatic logic [W-1:0] exp_rise();
    return hist_at(1) & ~hist_at(2);
  endfunction

  function automatic logic [W-1:0] exp_fall();
    return ~hist_at(1) & hist_at(2);
  endfunction

  function automatic logic [CW-1:0] exp_cnt();
`ifdef NOR_GATE_STATS_EN
    int m;
    m = (1 << CW) - 1;
    return (ones > m) ? CW'(m) : CW'(ones);
`else
    return {CW{1'b0}};
`endif
  endfunction

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    @(negedge clk);
    bus4.a = a;
    bus4.b = b;
    rst    = r;
  endtask

  task automatic tick();
    logic [W-1:0] s;
    @(posedge clk);
    if (rst) begin
      hist.delete();
      ones = 0;
    end else begin
      s = ~(bus4.a | bus4.b);
      hist.push_back(s);
      if (s == {W{1'b1}}) ones++;
      if (hist.size() > 3) void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic r);
    drive(a, b, r);
    tick();
  endtask

  task automatic test_reset();
    step(4'b0000, 4'b0000, 1'b1);
    checks++;
    if (bus4.y_q !== 4'b0000) begin errors++; $display("FAIL reset_y_q got %b need 0000", bus4.y_q); end
    checks++;
    if (bus4.y_rise !== 4'b0000 || bus4.y_fall !== 4'b0000) begin
      errors++; $display("FAIL reset_edges got rise=%b fall=%b need 0000", bus4.y_rise, bus4.y_fall);
    end
    checks++;
    if (bus4.all_cnt !== 2'd0) begin errors++; $display("FAIL reset_cnt got %0d need 0", bus4.all_cnt); end
    checks++;
    if (bus4.y !== 4'b1111) begin errors++; $display("FAIL reset_y_comb got %b need 1111", bus4.y); end
  endtask

  task automatic test_truth_table();
    logic [3:0] exp_tab;
    logic [1:0] idx;
    exp_tab = 4'b0001;
    for (int i = 0; i < 4; i++) begin
      idx = i[1:0];
      bus1.a = idx[1:1];
      bus1.b = idx[0:0];
      #20;
      checks++;
      if (bus1.y !== exp_tab[i]) begin
        errors++; $display("FAIL truth_y a=%b b=%b got %b need %b", bus1.a, bus1.b, bus1.y, exp_tab[i]);
      end
      checks++;
      if (bus1.y_q !== 1'b0 || bus1.all_cnt !== 16'd0) begin
        errors++; $display("FAIL truth_held_in_reset got y_q=%b cnt=%0d need 0/0", bus1.y_q, bus1.all_cnt);
      end
    end
  endtask

  task automatic test_rise();
    step(4'b0000, 4'b0000, 1'b1);
    drive(4'b0101, 4'b0011, 1'b0);
    #1;
    checks++;
    if (bus4.y !== 4'b1000) begin errors++; $display("FAIL rise_y_comb got %b need 1000", bus4.y); end
    tick();
    checks++;
    if (bus4.y_q !== 4'b1000 || bus4.y_rise !== 4'b0000) begin
      errors++; $display("FAIL rise_edge1 got y_q=%b rise=%b need 1000/0000", bus4.y_q, bus4.y_rise);
    end
    step(4'b0101, 4'b0011, 1'b0);
    checks++;
    if (bus4.y_rise !== 4'b1000) begin errors++; $display("FAIL rise_pulse got %b need 1000", bus4.y_rise); end
    step(4'b0101, 4'b0011, 1'b0);
    checks++;
    if (bus4.y_rise !== 4'b0000 || bus4.y_fall !== 4'b0000) begin
      errors++; $display("FAIL rise_one_cycle got rise=%b fall=%b need 0000", bus4.y_rise, bus4.y_fall);
    end
  endtask

  task automatic test_fall();
    for (int i = 0; i < 3; i++) step(4'b0000, 4'b0000, 1'b0);
    checks++;
    if (bus4.y_q !== 4'b1111) begin errors++; $display("FAIL fall_setup got %b need 1111", bus4.y_q); end
    step(4'b1111, 4'b0000, 1'b0);
    checks++;
    if (bus4.y_q !== 4'b0000 || bus4.y_fall !== 4'b0000) begin
      errors++; $display("FAIL fall_edge1 got y_q=%b fall=%b need 0000/0000", bus4.y_q, bus4.y_fall);
    end
    step(4'b1111, 4'b0000, 1'b0);
    checks++;
    if (bus4.y_fall !== 4'b1111 || bus4.y_rise !== 4'b0000) begin
      errors++; $display("FAIL fall_pulse got fall=%b rise=%b need 1111/0000", bus4.y_fall, bus4.y_rise);
    end
    step(4'b1111, 4'b0000, 1'b0);
    checks++;
    if (bus4.y_fall !== 4'b0000) begin errors++; $display("FAIL fall_one_cycle got %b need 0000", bus4.y_fall); end
  endtask

  task automatic test_saturate_and_reset();
    logic [CW-1:0] seq [5];
`ifdef NOR_GATE_STATS_EN
    seq = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
`else
    seq = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0};
`endif
    step(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 5; i++) begin
      step(4'b0000, 4'b0000, 1'b0);
      checks++;
      if (bus4.all_cnt !== seq[i]) begin
        errors++; $display("FAIL sat_cnt cycle %0d got %0d need %0d", i, bus4.all_cnt, seq[i]);
      end
    end
    step(4'b0000, 4'b0000, 1'b1);
    checks++;
    if (bus4.all_cnt !== 2'd0 || bus4.y_q !== 4'b0000 || bus4.y_fall !== 4'b0000) begin
      errors++; $display("FAIL mid_reset got cnt=%0d y_q=%b fall=%b need 0/0000/0000",
                         bus4.all_cnt, bus4.y_q, bus4.y_fall);
    end
    step(4'b0000, 4'b0000, 1'b0);
    checks++;
    if (bus4.y_q !== 4'b1111 || bus4.y_rise !== 4'b0000) begin
      errors++; $display("FAIL post_reset1 got y_q=%b rise=%b need 1111/0000", bus4.y_q, bus4.y_rise);
    end
    step(4'b0000, 4'b0000, 1'b0);
    checks++;
    if (bus4.y_rise !== 4'b1111) begin errors++; $display("FAIL post_reset_rise got %b need 1111", bus4.y_rise); end
  endtask

  task automatic test_random();
    logic [W-1:0] ra, rb;
    logic         rr;
    for (int n = 0; n < 300; n++) begin
      rr = ($urandom_range(19) == 0);
      if ($urandom_range(2) == 0) begin
        ra = {W{1'b0}};
        rb = {W{1'b0}};
      end else begin
        ra = W'($urandom) & W'($urandom);
        rb = W'($urandom) & W'($urandom);
      end
      drive(ra, rb, rr);
      #1;
      checks++;
      if (bus4.y !== ~(ra | rb)) begin
        errors++; $display("FAIL rand_y n=%0d got %b need %b", n, bus4.y, ~(ra | rb));
      end
      tick();
      checks++;
      if (bus4.y_q !== exp_yq() || bus4.y_rise !== exp_rise() || bus4.y_fall !== exp_fall()) begin
        errors++; $display("FAIL rand_regs n=%0d got q=%b r=%b f=%b need q=%b r=%b f=%b", n,
                           bus4.y_q, bus4.y_rise, bus4.y_fall, exp_yq(), exp_rise(), exp_fall());
      end
      checks++;
      if (bus4.all_cnt !== exp_cnt()) begin
        errors++; $display("FAIL rand_cnt n=%0d got %0d need %0d", n, bus4.all_cnt, exp_cnt());
      end
    end
  endtask

  initial begin
    bus4.a = 4'b0000;
    bus4.b = 4'b0000;
    bus1.a = 1'b0;
    bus1.b = 1'b0;
    test_reset();
    test_truth_table();
    test_rise();
    test_fall();
    test_saturate_and_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
